// File: rtl/alsu_pkg.sv
// Shared types and widths for the ALSU result serializer and its FIFO.
package alsu_pkg;

  localparam int DATA_W     = 6;
  localparam int LED_W      = 16;
  localparam int ENTRY_W    = 7;
  localparam int FRAME_BITS = 9;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    FLAG,
    STOP
  } state_t;

endpackage

// File: rtl/alsu_result_fifo.sv
// Synchronous FIFO of {err, result} entries; full/empty are registered from the next count.
module alsu_result_fifo
  import alsu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(FIFO_DEPTH);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     count_n;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + CNT_ONE;
      2'b01:   count_n = count - CNT_ONE;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_n;
      full  <= (count_n == CNT_MAX);
      empty <= (count_n == '0);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alsu_result_serializer.sv
// Captures ALSU results with an LED-change error flag, buffers them, and streams
// each as a 9-bit UART-style frame: start, 6 data bits LSB first, flag, stop.
module alsu_result_serializer
  import alsu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alsu_out,
  input  logic [LED_W-1:0]  alsu_leds,
  input  logic              capture_en,
  output logic              tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

  state_t             state;
  state_t             state_n;
  logic [LED_W-1:0]   leds_prev;
  logic               err;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic               pop;
  logic               last_baud;
  logic               start_frame;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BAUD_W-1:0]  baud_n;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_n;
  logic [DATA_W-1:0]  data_sr;
  logic [DATA_W-1:0]  data_n;
  logic               flag_bit;
  logic               flag_n;
  logic               tx_n;
  logic               busy_n;

  assign err   = (alsu_leds != leds_prev);
  assign entry = {err, alsu_out};

  alsu_result_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (capture_en),
    .pop    (pop),
    .wr_data(entry),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign last_baud   = (baud_cnt == BAUD_LAST);
  // A new frame starts from idle or straight out of the last stop-bit cycle.
  assign start_frame = !fifo_empty && ((state == IDLE) || ((state == STOP) && last_baud));

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    data_n  = data_sr;
    flag_n  = flag_bit;
    tx_n    = tx;
    busy_n  = busy;
    pop     = 1'b0;

    if (state != IDLE) baud_n = last_baud ? '0 : baud_cnt + BAUD_ONE;

    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        tx_n   = 1'b1;
        busy_n = 1'b0;
      end
      START: begin
        if (last_baud) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = data_sr[0];
        end
      end
      DATA: begin
        if (last_baud) begin
          if (bit_cnt == BIT_LAST) begin
            state_n = FLAG;
            tx_n    = flag_bit;
          end else begin
            bit_n  = bit_cnt + BIT_ONE;
            data_n = data_sr >> 1;
            tx_n   = data_sr[1];
          end
        end
      end
      FLAG: begin
        if (last_baud) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (last_baud) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (start_frame) begin
      pop     = 1'b1;
      state_n = START;
      baud_n  = '0;
      data_n  = head[DATA_W-1:0];
      flag_n  = head[ENTRY_W-1];
      tx_n    = 1'b0;
      busy_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      leds_prev  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      tx        <= tx_n;
      busy      <= busy_n;
      leds_prev <= alsu_leds;
      // Fullness is the pre-edge registered flag, so a same-edge pop does not rescue the sample.
      if (capture_en && fifo_full) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    data_sr  <= data_n;
    flag_bit <= flag_n;
  end

endmodule

// File: tb/tb_alsu_result_serializer.sv
// Directed bench for alsu_result_serializer with FIFO_DEPTH=4, BAUD_DIV=2.
module tb_alsu_result_serializer;
  import alsu_pkg::*;

  localparam int DEPTH = 4;
  localparam int BAUD  = 2;
  localparam int FRAME_CYC = FRAME_BITS * BAUD;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] alsu_out = '0;
  logic [LED_W-1:0]  alsu_leds = '0;
  logic              capture_en = 1'b0;
  logic              tx;
  logic              busy;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;
  logic [7:0]        drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alsu_result_serializer #(
    .FIFO_DEPTH(DEPTH),
    .BAUD_DIV  (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alsu_out  (alsu_out),
    .alsu_leds (alsu_leds),
    .capture_en(capture_en),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit i of a frame: 0 start, 1..6 data LSB first, 7 flag, 8 stop.
  function automatic logic frame_bit(input logic [DATA_W-1:0] d, input logic e, input int i);
    logic [DATA_W-1:0] t;
    if (i == 0) return 1'b0;
    if (i <= DATA_W) begin
      t = d >> (i - 1);
      return t[0];
    end
    if (i == DATA_W + 1) return e;
    return 1'b1;
  endfunction

  task automatic run_frame(input string tag, input logic [DATA_W-1:0] d, input logic e,
                           output int busy_cyc);
    busy_cyc = 0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      chk(tag, 32'(tx), 32'(frame_bit(d, e, k / BAUD)));
      if (busy) busy_cyc++;
      step();
    end
  endtask

  initial begin
    int bc;
    int lows;

    // 1. reset with random inputs
    for (int i = 0; i < 3; i++) begin
      alsu_out   = DATA_W'($urandom);
      alsu_leds  = LED_W'($urandom);
      capture_en = 1'($urandom);
      step();
    end
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    rst = 1'b1;
    capture_en = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    chk("idle_tx_low_cycles", 32'(lows), 32'd0);
    chk("idle_empty", 32'(fifo_empty), 32'd1);

    // 2. single sample
    alsu_leds = 16'h1234;
    step();
    step();
    alsu_out   = 6'b101101;
    capture_en = 1'b1;
    step();
    capture_en = 1'b0;
    chk("t2_pre_start", 32'(tx), 32'd1);
    step();
    run_frame("t2_tx", 6'b101101, 1'b0, bc);
    chk("t2_busy_len", 32'(bc), 32'(FRAME_CYC));
    chk("t2_busy_end", 32'(busy), 32'd0);

    // 3. error flag from an LED change on the capture cycle
    alsu_leds = 16'h0000;
    step();
    step();
    alsu_leds  = 16'hFFFF;
    alsu_out   = 6'b000000;
    capture_en = 1'b1;
    step();
    capture_en = 1'b0;
    step();
    run_frame("t3_tx", 6'b000000, 1'b1, bc);
    chk("t3_busy_len", 32'(bc), 32'(FRAME_CYC));
    chk("t3_busy_end", 32'(busy), 32'd0);

    // 4. overflow: 8 back-to-back captures, 1 popped, 2..5 stored, 6..8 dropped
    bc = 0;
    capture_en = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      alsu_out = DATA_W'(v);
      step();
      if (v >= 2) begin
        chk("t4_tx", 32'(tx), 32'(frame_bit(6'd1, 1'b0, (v - 2) / BAUD)));
        if (busy) bc++;
      end
      if (v == 5) chk("t4_full", 32'(fifo_full), 32'd1);
    end
    capture_en = 1'b0;
    chk("t4_drops", 32'(drop_count), 32'd3);
    chk("t4_ovf", 32'(overflow), 32'd1);
    for (int k = 7; k < 5 * FRAME_CYC; k++) begin
      step();
      chk("t4_tx", 32'(tx),
          32'(frame_bit(DATA_W'(k / FRAME_CYC + 1), 1'b0, (k % FRAME_CYC) / BAUD)));
      if (busy) bc++;
    end
    step();
    chk("t4_busy_len", 32'(bc), 32'(5 * FRAME_CYC));
    chk("t4_busy_end", 32'(busy), 32'd0);
    chk("t4_empty", 32'(fifo_empty), 32'd1);

    // 5. drop counter saturation
    alsu_out   = 6'h2A;
    capture_en = 1'b1;
    repeat (400) step();
    chk("t5_sat", 32'(drop_count), 32'd255);
    chk("t5_ovf", 32'(overflow), 32'd1);
    chk("t5_full", 32'(fifo_full), 32'd1);
    repeat (40) step();
    chk("t5_sat_hold", 32'(drop_count), 32'd255);
    capture_en = 1'b0;
    rst = 1'b0;
    step();
    chk("t5_rst_drops", 32'(drop_count), 32'd0);
    rst = 1'b1;
    step();

    // 6. reset during data bit 3 of a frame, with a second entry still queued
    capture_en = 1'b1;
    alsu_out   = 6'b000111;
    step();
    alsu_out = 6'b111111;
    step();
    capture_en = 1'b0;
    repeat (8) step();
    chk("t6_bit3", 32'(tx), 32'd0);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    chk("t6_queued", 32'(fifo_empty), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_tx", 32'(tx), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_empty", 32'(fifo_empty), 32'd1);
    step();
    rst = 1'b1;
    lows = 0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tx !== 1'b1) lows++;
      if (busy) bc++;
    end
    chk("t6_no_residual_tx", 32'(lows), 32'd0);
    chk("t6_no_residual_busy", 32'(bc), 32'd0);
    chk("t6_empty", 32'(fifo_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alsu_result_serializer.md
Name: alsu_result_serializer

Overview:
Downstream consumer of the ALSU result stage. Samples the ALSU 6-bit result and 16-bit LED word. Buffers each sample in a small FIFO, tagged with an error flag. Serialises each entry onto a single-wire, UART-style debug output so the board can stream results off-chip. Runs in the ALSU clock domain.

Parameters:
FIFO_DEPTH, 4, number of buffered entries; power of two, 2..16.
BAUD_DIV, 4, clock cycles per serial bit; must be 1 or more.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset; asynchronous, active-low (rst=0 resets).
alsu_out  input  6  ALSU result word.
alsu_leds  input  16  ALSU LED word; it toggles on invalid operations.
capture_en  input  1  when 1, sample alsu_out this cycle.
tx  output  1  serial line; idles high.
busy  output  1  1 while a frame is on tx.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
fifo_empty  output  1  FIFO holds 0 entries.
overflow  output  1  sticky; set on the first dropped sample.
drop_count  output  8  number of dropped samples; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0, drop_count=0. FIFO pointers, internal leds_prev and bit counters are cleared; state=IDLE. Reset mid-frame aborts the frame and forces tx=1 immediately.
- Error flag: err = (alsu_leds != leds_prev). leds_prev <= alsu_leds every cycle, independent of capture_en.
- Entry format: 7 bits, {err, alsu_out}.
- Push: on an edge with capture_en=1, the entry is written if the FIFO is not full.
  - If the FIFO is full, the entry is dropped: overflow <= 1, drop_count increments (holds at 255).
  - Fullness is evaluated before any same-cycle pop, so a sample arriving while full is dropped even if a pop occurs that edge.
- Pop: only on a transition into START. Pop and push may occur on the same edge when the FIFO is not full.
- FSM states: IDLE, START, DATA, FLAG, STOP.
  - IDLE: tx=1, busy=0. If fifo_empty=0, pop the head into the shift register and go to START.
  - START: tx=0 for BAUD_DIV cycles, then DATA.
  - DATA: alsu_out bits sent LSB first, each for BAUD_DIV cycles; after bit 5, go to FLAG.
  - FLAG: tx=err for BAUD_DIV cycles, then STOP.
  - STOP: tx=1 for BAUD_DIV cycles. On the last cycle, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- busy=1 in every state except IDLE.
- Frame: 9 bits, 9*BAUD_DIV cycles.
- Latency: a sample captured at edge N is in the FIFO after N. If the FSM is idle, it pops at edge N+1, and tx=0 starts in the cycle after N+1.
- tx, busy, fifo_full and fifo_empty are registered outputs; none are combinational from inputs.
- Bit counter and baud counter wrap to 0 at each bit/frame boundary.

Decomposition:
- Package alsu_pkg holds:
  - the state enum (IDLE, START, DATA, FLAG, STOP);
  - DATA_W=6, LED_W=16, ENTRY_W=7, FRAME_BITS=9;
  - DROP_MAX=8'hFF.
- Sub-module alsu_result_fifo: synchronous FIFO, width ENTRY_W, depth FIFO_DEPTH, with push/pop/full/empty.
  - The count register is one bit wider than the pointers.
  - Drop and saturation logic stays in the top module.

Test Plan (FIFO_DEPTH=4, BAUD_DIV=2):
1. Reset: rst=0 for 3 cycles with random inputs. Require tx=1, busy=0, fifo_empty=1, overflow=0, drop_count=0. Release rst and hold capture_en=0 for 20 cycles: tx stays 1.
2. Single sample: alsu_out=6'b101101, alsu_leds constant, capture_en=1 for one cycle. tx must carry 0,1,0,1,1,0,1,0,1, each bit for 2 cycles, starting 2 edges after capture. busy=1 for exactly 18 cycles.
3. Error flag: alsu_leds goes 16'h0000 -> 16'hFFFF on the capture cycle, with alsu_out=6'b000000. Frame must be 0,000000,1,1 (flag bit = 1).
4. Overflow: capture_en=1 for 8 consecutive cycles with values 1..8 while idle. Require:
   - value 1 popped;
   - values 2..5 stored, with fifo_full=1;
   - values 6,7,8 dropped: drop_count=3, overflow=1.
   - The 5 frames then transmit 1..5 back-to-back, with busy continuously 1 for 90 cycles, then fifo_empty=1.
5. Saturation: force 300 drops while full. drop_count must read 255 and stay at 255.
6. Reset mid-frame: assert rst=0 during DATA bit 3. tx=1 and busy=0 immediately. After release, no residual frame is sent and fifo_empty=1.
